// File: rtl/serial_link_pkg.sv
// Shared definitions for the 4-bit serial link: FSM state encoding and default frame geometry
// used by the transmitter, the receiver and the bench.
package serial_link_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2
    } state_t;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_GAP_MAX = 8;

endpackage

// File: rtl/serial_nibble_receiver_if.sv
// Serial-in / parallel-out bundle of the nibble receiver; slave = receiver side, master = driver side.
// PAR_ERR exists only when SERIAL_RX_PARITY_EN is defined.
interface serial_nibble_receiver_if
    import serial_link_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             S_IN;
    logic             S_EN;
    logic             S_SOF;
    logic             DATA_ACK;
    logic [WIDTH-1:0] Q;
    logic             DATA_VALID;
    logic             OVERRUN;
    logic             TIMEOUT_ERR;
    logic             BUSY;
`ifdef SERIAL_RX_PARITY_EN
    logic             PAR_ERR;

    modport slave  (input  S_IN, S_EN, S_SOF, DATA_ACK,
                    output Q, DATA_VALID, OVERRUN, TIMEOUT_ERR, BUSY, PAR_ERR);
    modport master (output S_IN, S_EN, S_SOF, DATA_ACK,
                    input  Q, DATA_VALID, OVERRUN, TIMEOUT_ERR, BUSY, PAR_ERR);
`else
    modport slave  (input  S_IN, S_EN, S_SOF, DATA_ACK,
                    output Q, DATA_VALID, OVERRUN, TIMEOUT_ERR, BUSY);
    modport master (output S_IN, S_EN, S_SOF, DATA_ACK,
                    input  Q, DATA_VALID, OVERRUN, TIMEOUT_ERR, BUSY);
`endif
endinterface

// File: rtl/rx_shift_core.sv
// Shift register + bit counter; o_word/o_done are combinational views of the word as it will be
// after this cycle's bit, so the top can load Q on the same edge that samples the last bit.
module rx_shift_core #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_shift,
    input  logic             i_clear,
    input  logic             i_bit,
    output logic [WIDTH-1:0] o_word,
    output logic             o_done
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] w_base;
    logic [WIDTH-1:0] w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_take;

    always_comb begin
        w_take    = i_start || i_shift;
        w_base    = i_start ? '0 : r_sr;
        w_cnt_nxt = i_start ? CNT_W'(1) : r_cnt + CNT_W'(1);
        o_word    = w_take ? w_next : r_sr;
        o_done    = w_take && (w_cnt_nxt == CNT_FULL);
    end

    generate
        if (WIDTH == 1) begin : g_one
            assign w_next = i_bit;
        end else if (MSB_FIRST) begin : g_msb
            assign w_next = {w_base[WIDTH-2:0], i_bit};
        end else begin : g_lsb
            assign w_next = {i_bit, w_base[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (w_take) begin
            r_sr  <= w_next;
            r_cnt <= o_done ? '0 : w_cnt_nxt;
        end else if (i_clear) begin
            r_cnt <= '0;
        end
    end

endmodule

// File: rtl/serial_nibble_receiver.sv
// Serial-to-parallel receiver: Q/DATA_VALID one cycle after the last bit; held until DATA_ACK,
// a new word overwrites and flags OVERRUN. Even parity bit + PAR state with SERIAL_RX_PARITY_EN.
module serial_nibble_receiver
    import serial_link_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter bit MSB_FIRST = 1'b1,
    parameter int GAP_MAX   = DEF_GAP_MAX
) (
    input  logic                    CLK,
    input  logic                    RESET,
    serial_nibble_receiver_if.slave bus
);
    localparam logic [7:0] GAP_LIM = 8'(GAP_MAX);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_gap;
    logic [7:0]       w_gap_inc;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_word;
    logic             r_vld;
    logic             r_ovr;
    logic             r_tmo;
    logic             w_start;
    logic             w_shift;
    logic             w_done;
    logic             w_timeout;
    logic             w_complete;
`ifdef SERIAL_RX_PARITY_EN
    logic             r_perr;
    logic             w_par_bit;
    logic             w_par_bad;
`endif

    rx_shift_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_core (
        .clk     (CLK),
        .rst_n   (RESET),
        .i_start (w_start),
        .i_shift (w_shift),
        .i_clear (w_timeout),
        .i_bit   (bus.S_IN),
        .o_word  (w_word),
        .o_done  (w_done)
    );

    // SOF restarts the frame from any state, silently dropping a partial one.
    always_comb begin
        w_start   = bus.S_EN && bus.S_SOF;
        w_shift   = bus.S_EN && !bus.S_SOF && (r_state == ST_SHIFT);
        w_gap_inc = (r_gap == 8'hFF) ? r_gap : r_gap + 8'd1;
        w_timeout = (r_state != ST_IDLE) && !bus.S_EN && (w_gap_inc >= GAP_LIM);
`ifdef SERIAL_RX_PARITY_EN
        w_par_bit  = bus.S_EN && !bus.S_SOF && (r_state == ST_PAR);
        w_par_bad  = w_par_bit && ((^w_word) != bus.S_IN);
        w_complete = w_par_bit && !w_par_bad;
`else
        w_complete = w_done;
`endif
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_start || w_shift) begin
            if (w_done) begin
`ifdef SERIAL_RX_PARITY_EN
                w_state_nxt = ST_PAR;
`else
                w_state_nxt = ST_IDLE;
`endif
            end else begin
                w_state_nxt = ST_SHIFT;
            end
        end else if (w_timeout) begin
            w_state_nxt = ST_IDLE;
        end
`ifdef SERIAL_RX_PARITY_EN
        else if (w_par_bit) begin
            w_state_nxt = ST_IDLE;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state <= ST_IDLE;
            r_gap   <= '0;
            r_q     <= '0;
            r_vld   <= 1'b0;
            r_ovr   <= 1'b0;
            r_tmo   <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            r_perr  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_gap   <= (bus.S_EN || (w_state_nxt == ST_IDLE)) ? '0 : w_gap_inc;
            r_tmo   <= w_timeout;
            // A simultaneous ack retires the old word, so the new one is not an overrun.
            if (w_complete) begin
                r_q   <= w_word;
                r_vld <= 1'b1;
                if (r_vld && !bus.DATA_ACK) begin
                    r_ovr <= 1'b1;
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            else if (w_par_bad) begin
                r_q   <= w_word;
                r_vld <= 1'b0;
            end
`endif
            else if (bus.DATA_ACK) begin
                r_vld <= 1'b0;
            end
`ifdef SERIAL_RX_PARITY_EN
            r_perr <= w_par_bad;
`endif
        end
    end

    assign bus.Q           = r_q;
    assign bus.DATA_VALID  = r_vld;
    assign bus.OVERRUN     = r_ovr;
    assign bus.TIMEOUT_ERR = r_tmo;
    assign bus.BUSY        = (r_state == ST_SHIFT);
`ifdef SERIAL_RX_PARITY_EN
    assign bus.PAR_ERR     = r_perr;
`endif

endmodule
